// File: rtl/wb_downsizer.sv
// Purpose: Wishbone B3 width downsizer; splits one wide access into one narrow beat per active lane, ascending address.
// Latency: N active lanes with zero-wait slave -> beats in cycles 1..N, master response in cycle N+1.
// Backpressure: each beat holds stb until slave ack/err/rty; WB_DOWNSIZER_TIMEOUT_EN bounds each beat to TIMEOUT cycles.
module wb_downsizer #(
    parameter int AW         = 32,
    parameter int MDW        = 32,
    parameter int SDW        = 8,
    parameter int BIG_ENDIAN = 1,
    parameter int TIMEOUT    = 255
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [AW-1:0]    wbm_adr_i,
    input  logic [MDW-1:0]   wbm_dat_i,
    input  logic [MDW/8-1:0] wbm_sel_i,
    input  logic             wbm_we_i,
    input  logic             wbm_cyc_i,
    input  logic             wbm_stb_i,
    input  logic [2:0]       wbm_cti_i,
    input  logic [1:0]       wbm_bte_i,
    output logic [MDW-1:0]   wbm_dat_o,
    output logic             wbm_ack_o,
    output logic             wbm_err_o,
    output logic             wbm_rty_o,
    output logic [AW-1:0]    wbs_adr_o,
    output logic [SDW-1:0]   wbs_dat_o,
    output logic [SDW/8-1:0] wbs_sel_o,
    output logic             wbs_we_o,
    output logic             wbs_cyc_o,
    output logic             wbs_stb_o,
    output logic [2:0]       wbs_cti_o,
    output logic [1:0]       wbs_bte_o,
    input  logic [SDW-1:0]   wbs_dat_i,
    input  logic             wbs_ack_i,
    input  logic             wbs_err_i,
    input  logic             wbs_rty_i
);
    localparam int R  = MDW / SDW;     // narrow lanes per wide word
    localparam int SB = SDW / 8;       // bytes per lane
    localparam int MB = MDW / 8;       // bytes per wide word
    localparam int AB = $clog2(MB);    // address bits replaced by the lane offset
    localparam int LW = $clog2(R);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BEAT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [1:0] RK_ACK = 2'd0;
    localparam logic [1:0] RK_ERR = 2'd1;
    localparam logic [1:0] RK_RTY = 2'd2;

    logic [1:0]     state;
    logic [AW-AB-1:0] adr_q;
    logic [MDW-1:0] dat_q;
    logic [MB-1:0]  sel_q;
    logic           we_q;
    logic [LW-1:0]  lane_q;
    logic [1:0]     kind_q;
    logic [MDW-1:0] rbuf;
    logic           timed_out;
    logic           in_beat;
    int             cur_grp;
    logic [LW:0]    first_req;
    logic [LW:0]    next_lane;

    // Lane k is counted in address order; map it to its bit group in the wide word.
    function automatic int grp_of(input int k);
        return (BIG_ENDIAN != 0) ? (R - 1 - k) : k;
    endfunction

    function automatic logic [R-1:0] lanes_of(input logic [MB-1:0] s);
        logic [R-1:0] m;
        m = '0;
        for (int k = 0; k < R; k++)
            m[k] = |s[grp_of(k)*SB +: SB];
        return m;
    endfunction

    // Lowest active lane at or above start; top bit flags that one exists.
    function automatic logic [LW:0] first_lane(input logic [R-1:0] m, input int start);
        logic [LW:0] r;
        r = '0;
        for (int k = R - 1; k >= 0; k--)
            if (m[k] && (k >= start))
                r = {1'b1, LW'(k)};
        return r;
    endfunction

    assign in_beat   = (state == BEAT);
    assign cur_grp   = grp_of(int'(lane_q));
    assign first_req = first_lane(lanes_of(wbm_sel_i), 0);
    assign next_lane = first_lane(lanes_of(sel_q), int'(lane_q) + 1);

    // Request sequencing: latch request, walk active lanes, collect read data, record final status.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state  <= IDLE;
            adr_q  <= '0;
            dat_q  <= '0;
            sel_q  <= '0;
            we_q   <= 1'b0;
            lane_q <= '0;
            kind_q <= RK_ACK;
            rbuf   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wbm_cyc_i && wbm_stb_i) begin
                        adr_q  <= wbm_adr_i[AW-1:AB];
                        dat_q  <= wbm_dat_i;
                        sel_q  <= wbm_sel_i;
                        we_q   <= wbm_we_i;
                        rbuf   <= '0;
                        kind_q <= RK_ACK;
                        lane_q <= first_req[LW-1:0];
                        state  <= first_req[LW] ? BEAT : RESP;
                    end
                end
                BEAT: begin
                    if (!wbm_cyc_i) begin
                        state <= IDLE;          // master abort: no response owed
                    end else if (wbs_err_i) begin
                        kind_q <= RK_ERR;
                        state  <= RESP;
                    end else if (wbs_rty_i) begin
                        kind_q <= RK_RTY;
                        state  <= RESP;
                    end else if (wbs_ack_i) begin
                        if (!we_q)
                            rbuf[cur_grp*SDW +: SDW] <= wbs_dat_i;
                        if (next_lane[LW])
                            lane_q <= next_lane[LW-1:0];
                        else
                            state <= RESP;
                    end else if (timed_out) begin
                        kind_q <= RK_ERR;
                        state  <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WB_DOWNSIZER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] tcnt;

    assign timed_out = (tcnt == CW'(TIMEOUT));

    // Per-beat watchdog: restarts on every new beat, counts silent BEAT cycles.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || !in_beat || wbs_ack_i || wbs_err_i || wbs_rty_i)
            tcnt <= '0;
        else if (!timed_out)
            tcnt <= tcnt + 1'b1;
    end
`else
    assign timed_out = 1'b0;
`endif

    // Slave-side drive: only meaningful while a beat is in flight, zero otherwise.
    always_comb begin
        wbs_adr_o = '0;
        wbs_dat_o = '0;
        wbs_sel_o = '0;
        wbs_we_o  = 1'b0;
        if (in_beat) begin
            wbs_adr_o = {adr_q, AB'(int'(lane_q) * SB)};
            wbs_dat_o = dat_q[cur_grp*SDW +: SDW];
            wbs_sel_o = sel_q[cur_grp*SB +: SB];
            wbs_we_o  = we_q;
        end
    end

    assign wbs_cyc_o = in_beat;
    assign wbs_stb_o = in_beat;
    assign wbs_cti_o = 3'b000;
    assign wbs_bte_o = 2'b00;

    assign wbm_ack_o = (state == RESP) && (kind_q == RK_ACK);
    assign wbm_err_o = (state == RESP) && (kind_q == RK_ERR);
    assign wbm_rty_o = (state == RESP) && (kind_q == RK_RTY);
    assign wbm_dat_o = (state == RESP) ? rbuf : '0;

    // Classic-only handling: burst hints and in-word address bits carry no information here.
    logic unused;
    assign unused = ^{wbm_cti_i, wbm_bte_i, wbm_adr_i[AB-1:0]};

endmodule

// File: tb/tb_wb_downsizer.sv
module tb_wb_downsizer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // shared master-side stimulus
    logic [31:0] m_adr = '0, m_dat = '0;
    logic [3:0]  m_sel = '0;
    logic        m_we = 1'b0, m_stb = 1'b0, m_cyc8 = 1'b0, m_cyc16 = 1'b0;

    // 32->8 big-endian instance
    logic [31:0] m8_dat; logic m8_ack, m8_err, m8_rty;
    logic [31:0] w8_adr; logic [7:0] w8_dat; logic [0:0] w8_sel;
    logic w8_we, w8_cyc, w8_stb; logic [2:0] w8_cti; logic [1:0] w8_bte;
    logic [7:0] s8_dat; logic s8_ack, s8_err, s8_rty, s8_ready;

    // 32->16 little-endian instance
    logic [31:0] m16_dat; logic m16_ack, m16_err, m16_rty;
    logic [31:0] w16_adr; logic [15:0] w16_dat; logic [1:0] w16_sel;
    logic w16_we, w16_cyc, w16_stb; logic [2:0] w16_cti; logic [1:0] w16_bte;
    logic [15:0] s16_dat;

    wb_downsizer #(.AW(32), .MDW(32), .SDW(8), .BIG_ENDIAN(1), .TIMEOUT(8)) dut8 (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_sel_i(m_sel), .wbm_we_i(m_we),
        .wbm_cyc_i(m_cyc8), .wbm_stb_i(m_stb), .wbm_cti_i(3'b000), .wbm_bte_i(2'b00),
        .wbm_dat_o(m8_dat), .wbm_ack_o(m8_ack), .wbm_err_o(m8_err), .wbm_rty_o(m8_rty),
        .wbs_adr_o(w8_adr), .wbs_dat_o(w8_dat), .wbs_sel_o(w8_sel), .wbs_we_o(w8_we),
        .wbs_cyc_o(w8_cyc), .wbs_stb_o(w8_stb), .wbs_cti_o(w8_cti), .wbs_bte_o(w8_bte),
        .wbs_dat_i(s8_dat), .wbs_ack_i(s8_ack), .wbs_err_i(s8_err), .wbs_rty_i(s8_rty));

    wb_downsizer #(.AW(32), .MDW(32), .SDW(16), .BIG_ENDIAN(0), .TIMEOUT(255)) dut16 (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_sel_i(m_sel), .wbm_we_i(m_we),
        .wbm_cyc_i(m_cyc16), .wbm_stb_i(m_stb), .wbm_cti_i(3'b000), .wbm_bte_i(2'b00),
        .wbm_dat_o(m16_dat), .wbm_ack_o(m16_ack), .wbm_err_o(m16_err), .wbm_rty_o(m16_rty),
        .wbs_adr_o(w16_adr), .wbs_dat_o(w16_dat), .wbs_sel_o(w16_sel), .wbs_we_o(w16_we),
        .wbs_cyc_o(w16_cyc), .wbs_stb_o(w16_stb), .wbs_cti_o(w16_cti), .wbs_bte_o(w16_bte),
        .wbs_dat_i(s16_dat), .wbs_ack_i(w16_stb), .wbs_err_i(1'b0), .wbs_rty_i(1'b0));

    // 8-bit slave: byte at offset n reads (n+1)*0x11; programmable wait, err/rty beat, silence
    int s_wait = 0, s_err_beat = -1, s_rty_beat = -1;
    bit s_silent = 1'b0;
    int wcnt = 0, bidx = 0;
    always_comb begin
        case (w8_adr[1:0])
            2'd0: s8_dat = 8'h11;
            2'd1: s8_dat = 8'h22;
            2'd2: s8_dat = 8'h33;
            default: s8_dat = 8'h44;
        endcase
        s8_ready = w8_stb && !s_silent && (wcnt >= s_wait);
        s8_err   = s8_ready && (bidx == s_err_beat);
        s8_rty   = s8_ready && !s8_err && (bidx == s_rty_beat);
        s8_ack   = s8_ready && !s8_err && !s8_rty;
    end
    always @(posedge clk) begin
        if (!m_cyc8) begin
            wcnt <= 0; bidx <= 0;
        end else if (w8_stb && s8_ready) begin
            wcnt <= 0; bidx <= bidx + 1;
        end else if (w8_stb) begin
            wcnt <= wcnt + 1;
        end
    end
    assign s16_dat = w16_adr[1] ? 16'h5678 : 16'h1234;

    int ncmp = 0, nerr = 0;
    // beat log of the 8-bit instance (completed beats only)
    logic [31:0] b_adr[8]; logic [7:0] b_dat[8]; logic b_we[8]; logic b_sel[8]; int b_cyc[8];
    int nb;
    int rc; logic [2:0] fl; logic [31:0] rd;

    // Issue one request to dut8, log completed beats, return response cycle/flags/data.
    task automatic req8(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic w, output int rcyc, output logic [2:0] flags,
                        output logic [31:0] rdat);
        @(negedge clk);
        m_adr = a; m_dat = d; m_sel = s; m_we = w; m_cyc8 = 1'b1; m_stb = 1'b1;
        nb = 0; rcyc = -1; flags = 3'b000; rdat = '0;
        for (int c = 1; c <= 40 && rcyc < 0; c++) begin
            @(negedge clk);
            if (w8_stb && (s8_ack || s8_err || s8_rty) && nb < 8) begin
                b_adr[nb] = w8_adr; b_dat[nb] = w8_dat; b_we[nb] = w8_we;
                b_sel[nb] = w8_sel[0]; b_cyc[nb] = c; nb++;
            end
            if (m8_ack || m8_err || m8_rty) begin
                rcyc = c; flags = {m8_ack, m8_err, m8_rty}; rdat = m8_dat;
                m_cyc8 = 1'b0; m_stb = 1'b0;
            end
        end
        m_cyc8 = 1'b0; m_stb = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        ncmp++;
        if ({m8_dat, m8_ack, m8_err, m8_rty, w8_adr, w8_dat, w8_sel, w8_we, w8_cyc, w8_stb, w8_cti, w8_bte} !== '0) begin
            nerr++; $display("FAIL reset8: outputs got %h expected 0",
                {m8_dat, m8_ack, m8_err, m8_rty, w8_adr, w8_dat, w8_sel, w8_we, w8_cyc, w8_stb});
        end
        ncmp++;
        if ({m16_dat, m16_ack, m16_err, m16_rty, w16_adr, w16_dat, w16_sel, w16_we, w16_cyc, w16_stb} !== '0) begin
            nerr++; $display("FAIL reset16: outputs got %h expected 0",
                {m16_dat, m16_ack, m16_err, m16_rty, w16_adr, w16_dat, w16_sel, w16_we, w16_cyc, w16_stb});
        end
        rst = 1'b0;
    endtask

    task automatic test_read_be;
        req8(32'h9000_0010, 32'h0, 4'hF, 1'b0, rc, fl, rd);
        ncmp++; if (nb !== 4) begin nerr++; $display("FAIL rd_be_beats: got %0d expected 4", nb); end
        for (int i = 0; i < 4 && i < nb; i++) begin
            ncmp++;
            if ({b_adr[i], b_we[i], b_cyc[i]} !== {32'h9000_0010 + 32'(i), 1'b0, i + 1}) begin
                nerr++; $display("FAIL rd_be_beat%0d: adr %h we %b cyc %0d expected adr %h we 0 cyc %0d",
                    i, b_adr[i], b_we[i], b_cyc[i], 32'h9000_0010 + 32'(i), i + 1);
            end
        end
        ncmp++; if (rc !== 5 || fl !== 3'b100) begin nerr++; $display("FAIL rd_be_resp: cyc %0d flags %b expected 5 100", rc, fl); end
        ncmp++; if (rd !== 32'h1122_3344) begin nerr++; $display("FAIL rd_be_data: got %h expected 11223344", rd); end
    endtask

    task automatic test_write;
        req8(32'h9000_0004, 32'hAABB_CCDD, 4'b0010, 1'b1, rc, fl, rd);
        ncmp++; if (nb !== 1) begin nerr++; $display("FAIL wr_beats: got %0d expected 1", nb); end
        ncmp++;
        if ({b_adr[0], b_dat[0], b_we[0], b_sel[0]} !== {32'h9000_0006, 8'hCC, 1'b1, 1'b1}) begin
            nerr++; $display("FAIL wr_beat: adr %h dat %h we %b sel %b expected 90000006 cc 1 1",
                b_adr[0], b_dat[0], b_we[0], b_sel[0]);
        end
        ncmp++; if (rc !== 2 || fl !== 3'b100) begin nerr++; $display("FAIL wr_resp: cyc %0d flags %b expected 2 100", rc, fl); end
    endtask

    task automatic test_err;
        s_err_beat = 0;
        req8(32'h9000_0020, 32'h0, 4'b1001, 1'b0, rc, fl, rd);
        ncmp++;
        if (nb !== 1 || b_adr[0] !== 32'h9000_0020) begin
            nerr++; $display("FAIL err_beats: count %0d adr %h expected 1 90000020", nb, b_adr[0]);
        end
        ncmp++; if (rc !== 2 || fl !== 3'b010) begin nerr++; $display("FAIL err_resp: cyc %0d flags %b expected 2 010", rc, fl); end
        @(negedge clk);
        ncmp++;
        if ({m8_ack, m8_err, m8_rty, w8_cyc} !== 4'b0000) begin
            nerr++; $display("FAIL err_single: ack/err/rty/cyc %b expected 0000", {m8_ack, m8_err, m8_rty, w8_cyc});
        end
        s_err_beat = -1;
    endtask

    task automatic test_zero_sel;
        req8(32'h9000_0008, 32'h0, 4'h0, 1'b0, rc, fl, rd);
        ncmp++;
        if (nb !== 0 || rc !== 1 || fl !== 3'b100) begin
            nerr++; $display("FAIL zero_sel: beats %0d cyc %0d flags %b expected 0 1 100", nb, rc, fl);
        end
    endtask

    task automatic test_wait;
        s_wait = 1;
        req8(32'h9000_0030, 32'h0, 4'b1100, 1'b0, rc, fl, rd);
        ncmp++;
        if (nb !== 2 || b_adr[0] !== 32'h9000_0030 || b_adr[1] !== 32'h9000_0031 || b_cyc[0] !== 2 || b_cyc[1] !== 4) begin
            nerr++; $display("FAIL wait_beats: n %0d adr %h/%h cyc %0d/%0d expected 2 90000030/90000031 2/4",
                nb, b_adr[0], b_adr[1], b_cyc[0], b_cyc[1]);
        end
        ncmp++;
        if (rc !== 5 || rd !== 32'h1122_0000) begin
            nerr++; $display("FAIL wait_resp: cyc %0d data %h expected 5 11220000", rc, rd);
        end
        s_wait = 0;
    endtask

    task automatic test_rty;
        s_rty_beat = 1;
        req8(32'h9000_0040, 32'h0, 4'hF, 1'b0, rc, fl, rd);
        ncmp++;
        if (nb !== 2 || b_adr[1] !== 32'h9000_0041 || rc !== 3 || fl !== 3'b001) begin
            nerr++; $display("FAIL rty: beats %0d adr1 %h cyc %0d flags %b expected 2 90000041 3 001", nb, b_adr[1], rc, fl);
        end
        s_rty_beat = -1;
    endtask

    task automatic test_back_to_back;
        req8(32'h9000_0050, 32'h1234_5678, 4'b0001, 1'b1, rc, fl, rd);
        ncmp++;
        if (b_adr[0] !== 32'h9000_0053 || b_dat[0] !== 8'h78 || rc !== 2) begin
            nerr++; $display("FAIL b2b_first: adr %h dat %h cyc %0d expected 90000053 78 2", b_adr[0], b_dat[0], rc);
        end
        req8(32'h9000_0060, 32'h0, 4'b0100, 1'b0, rc, fl, rd);
        ncmp++;
        if (b_adr[0] !== 32'h9000_0061 || rc !== 2 || rd !== 32'h0022_0000 || fl !== 3'b100) begin
            nerr++; $display("FAIL b2b_second: adr %h cyc %0d data %h flags %b expected 90000061 2 00220000 100",
                b_adr[0], rc, rd, fl);
        end
    endtask

    task automatic test_abort;
        logic seen;
        s_silent = 1'b1;
        @(negedge clk);
        m_adr = 32'h9000_0070; m_sel = 4'hF; m_we = 1'b0; m_cyc8 = 1'b1; m_stb = 1'b1;
        repeat (3) @(negedge clk);
        ncmp++; if (w8_cyc !== 1'b1) begin nerr++; $display("FAIL abort_hold: cyc %b expected 1", w8_cyc); end
        m_cyc8 = 1'b0; m_stb = 1'b0;
        @(negedge clk);
        ncmp++;
        if ({w8_cyc, w8_stb} !== 2'b00) begin nerr++; $display("FAIL abort_drop: cyc/stb %b expected 00", {w8_cyc, w8_stb}); end
        seen = 1'b0;
        repeat (3) begin @(negedge clk); seen |= m8_ack | m8_err | m8_rty; end
        ncmp++; if (seen !== 1'b0) begin nerr++; $display("FAIL abort_noresp: response %b expected 0", seen); end
        s_silent = 1'b0;
        req8(32'h9000_0074, 32'h0, 4'b0001, 1'b0, rc, fl, rd);
        ncmp++;
        if (rc !== 2 || rd !== 32'h0000_0044) begin
            nerr++; $display("FAIL abort_recover: cyc %0d data %h expected 2 00000044", rc, rd);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        m_adr = 32'h9000_0080; m_sel = 4'hF; m_we = 1'b0; m_cyc8 = 1'b1; m_stb = 1'b1;
        repeat (2) @(negedge clk);
        ncmp++; if (w8_adr !== 32'h9000_0081) begin nerr++; $display("FAIL rstmid_beat2: adr %h expected 90000081", w8_adr); end
        rst = 1'b1; m_cyc8 = 1'b0; m_stb = 1'b0;
        @(negedge clk);
        ncmp++;
        if ({m8_dat, m8_ack, m8_err, m8_rty, w8_adr, w8_dat, w8_sel, w8_we, w8_cyc, w8_stb} !== '0) begin
            nerr++; $display("FAIL rstmid_outputs: got %h expected 0",
                {m8_dat, m8_ack, m8_err, m8_rty, w8_adr, w8_dat, w8_sel, w8_we, w8_cyc, w8_stb});
        end
        rst = 1'b0;
    endtask

    task automatic test_sdw16_le;
        logic [31:0] a16[2]; logic [1:0] s16[2]; int c16[2]; int n16, r16; logic [31:0] d16;
        @(negedge clk);
        m_adr = 32'h9000_0070; m_sel = 4'hF; m_we = 1'b0; m_cyc16 = 1'b1; m_stb = 1'b1;
        n16 = 0; r16 = -1; d16 = '0;
        for (int c = 1; c <= 40 && r16 < 0; c++) begin
            @(negedge clk);
            if (w16_stb && n16 < 2) begin a16[n16] = w16_adr; s16[n16] = w16_sel; c16[n16] = c; n16++; end
            if (m16_ack || m16_err || m16_rty) begin r16 = c; d16 = m16_dat; m_cyc16 = 1'b0; m_stb = 1'b0; end
        end
        m_cyc16 = 1'b0; m_stb = 1'b0;
        ncmp++;
        if (n16 !== 2 || a16[0] !== 32'h9000_0070 || a16[1] !== 32'h9000_0072 || s16[0] !== 2'b11 ||
            s16[1] !== 2'b11 || c16[0] !== 1 || c16[1] !== 2) begin
            nerr++; $display("FAIL le16_beats: n %0d adr %h/%h sel %b/%b cyc %0d/%0d expected 2 90000070/90000072 11/11 1/2",
                n16, a16[0], a16[1], s16[0], s16[1], c16[0], c16[1]);
        end
        ncmp++;
        if (r16 !== 3 || d16 !== 32'h5678_1234) begin
            nerr++; $display("FAIL le16_resp: cyc %0d data %h expected 3 56781234", r16, d16);
        end
    endtask

`ifdef WB_DOWNSIZER_TIMEOUT_EN
    task automatic test_timeout;
        s_silent = 1'b1;
        req8(32'h9000_0090, 32'h0, 4'hF, 1'b0, rc, fl, rd);
        ncmp++;
        if (rc !== 10 || fl !== 3'b010 || nb !== 0) begin
            nerr++; $display("FAIL timeout: cyc %0d flags %b beats %0d expected 10 010 0", rc, fl, nb);
        end
        s_silent = 1'b0;
    endtask
`endif

    initial begin
        test_reset;
        test_read_be;
        test_write;
        test_err;
        test_zero_sel;
        test_wait;
        test_rty;
        test_back_to_back;
        test_abort;
        test_reset_mid;
        test_sdw16_le;
`ifdef WB_DOWNSIZER_TIMEOUT_EN
        test_timeout;
`endif
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
